// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard controller hookup: ID/EX fields in, pipeline register enables out
interface pipeline_hazard_ctrl_if #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) ();
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic              id_uses_rt;
   logic              ex_mem_read;
   logic [REG_AW-1:0] ex_rt;
   logic              ex_pc_src;
   logic              mem_req;
   logic              mem_ready;
   logic              pc_write;
   logic              if_id_write;
   logic              if_id_flush;
   logic              id_ex_flush;
   logic              id_ex_hold;
   logic              ex_mem_hold;
   logic [1:0]        state_o;
   logic              mem_timeout;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  flush_cnt;

   modport master (
      output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_pc_src, mem_req, mem_ready,
      input  pc_write, if_id_write, if_id_flush, id_ex_flush, id_ex_hold, ex_mem_hold,
             state_o, mem_timeout, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_pc_src, mem_req, mem_ready,
      output pc_write, if_id_write, if_id_flush, id_ex_flush, id_ex_hold, ex_mem_hold,
             state_o, mem_timeout, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - 5-stage pipeline hazard controller: load-use stall, branch flush, memory freeze
// Optional performance counters enabled by HAZARD_PERF_EN.
module pipeline_hazard_ctrl #(
   parameter int REG_AW      = 5,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input logic                   clk,
   input logic                   reset,
   pipeline_hazard_ctrl_if.slave hz
);
   typedef enum logic [1:0] {
      S_RUN      = 2'd0,
      S_STALL    = 2'd1,
      S_MEM_WAIT = 2'd2
   } state_e;

   localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

   state_e            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              timeout_q, timeout_d;
   logic              load_use;
   logic              mem_busy;
   logic              branch;
   logic              stall_evt;

   always_comb begin
      load_use = hz.ex_mem_read && (hz.ex_rt != {REG_AW{1'b0}}) &&
                 ((hz.ex_rt == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));
   end

   // Priority-resolved events of the current cycle: mem busy > branch > load-use.
   always_comb begin
      mem_busy  = 1'b0;
      branch    = 1'b0;
      stall_evt = 1'b0;
      case (state_q)
         S_MEM_WAIT: begin
            mem_busy  = !hz.mem_ready;
            branch    = hz.mem_ready && hz.ex_pc_src;
            stall_evt = hz.mem_ready && !hz.ex_pc_src && load_use;
         end
         S_STALL: begin
            mem_busy = hz.mem_req && !hz.mem_ready;
            branch   = !mem_busy && hz.ex_pc_src;
         end
         default: begin
            mem_busy  = hz.mem_req && !hz.mem_ready;
            branch    = !mem_busy && hz.ex_pc_src;
            stall_evt = !mem_busy && !hz.ex_pc_src && load_use;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_RUN;
         wait_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      wait_d    = '0;
      timeout_d = timeout_q;
      case (state_q)
         S_MEM_WAIT: begin
            if (mem_busy) begin
               state_d = S_MEM_WAIT;
               wait_d  = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
               if (wait_d == WAIT_MAX) begin
                  timeout_d = 1'b1;
               end
            end else begin
               state_d = stall_evt ? S_STALL : S_RUN;
            end
         end
         default: begin
            if (mem_busy) begin
               state_d = S_MEM_WAIT;
            end else if (stall_evt) begin
               state_d = S_STALL;
            end else begin
               state_d = S_RUN;
            end
         end
      endcase
   end

   always_comb begin
      hz.pc_write    = 1'b1;
      hz.if_id_write = 1'b1;
      hz.if_id_flush = 1'b0;
      hz.id_ex_flush = 1'b0;
      hz.id_ex_hold  = 1'b0;
      hz.ex_mem_hold = 1'b0;
      if (reset) begin
         hz.pc_write    = 1'b0;
         hz.if_id_write = 1'b0;
         hz.if_id_flush = 1'b1;
         hz.id_ex_flush = 1'b1;
      end else if (mem_busy) begin
         hz.pc_write    = 1'b0;
         hz.if_id_write = 1'b0;
         hz.id_ex_hold  = 1'b1;
         hz.ex_mem_hold = 1'b1;
      end else if (branch) begin
         hz.if_id_flush = 1'b1;
         hz.id_ex_flush = 1'b1;
      end else if (stall_evt) begin
         hz.pc_write    = 1'b0;
         hz.if_id_write = 1'b0;
         hz.id_ex_flush = 1'b1;
      end
   end

   assign hz.state_o     = state_q;
   assign hz.mem_timeout = timeout_q;

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall_evt && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
         end
         if (branch && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_q <= flush_cnt_q + 1'b1;
         end
      end
   end

   assign hz.stall_cnt = stall_cnt_q;
   assign hz.flush_cnt = flush_cnt_q;
`else
   assign hz.stall_cnt = {CNT_W{1'b0}};
   assign hz.flush_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench: directed scenarios plus randomized run against a behavioural model
module tb_pipeline_hazard_ctrl;
   localparam int REG_AW = 5;
   localparam int MT     = 4;
   localparam int CNT_W  = 16;
`ifdef HAZARD_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif
   localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;
   bit   chk_en = 1'b0;

   pipeline_hazard_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

   pipeline_hazard_ctrl #(.REG_AW(REG_AW), .MEM_TIMEOUT(MT), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: "waiting" = memory access outstanding, "pend" = the one-cycle load-use bubble slot.
   bit     m_wait = 0;
   bit     m_pend = 0;
   int     m_cnt  = 0;
   bit     m_to   = 0;
   longint m_stalls = 0;
   longint m_flushes = 0;

   always @(negedge clk) begin
      if (chk_en) begin
         bit luc, busy, br, lu;
         bit e_pc, e_ifw, e_iff, e_idf, e_idh, e_emh;
         luc = bus.ex_mem_read && (bus.ex_rt != 0) &&
               ((bus.ex_rt == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));
         chk("state_o", bus.state_o, m_wait ? 2 : (m_pend ? 1 : 0));
         chk("mem_timeout", bus.mem_timeout, m_to);
         chk("stall_cnt", bus.stall_cnt, PERF ? m_stalls : 0);
         chk("flush_cnt", bus.flush_cnt, PERF ? m_flushes : 0);
         if (reset) begin
            busy = 0; br = 0; lu = 0;
            e_pc = 0; e_ifw = 0; e_iff = 1; e_idf = 1; e_idh = 0; e_emh = 0;
         end else begin
            busy  = m_wait ? !bus.mem_ready : (bus.mem_req && !bus.mem_ready);
            br    = !busy && bus.ex_pc_src;
            lu    = !busy && !br && !m_pend && luc;
            e_pc  = !(busy || lu);
            e_ifw = !(busy || lu);
            e_iff = br;
            e_idf = br || lu;
            e_idh = busy;
            e_emh = busy;
         end
         chk("pc_write", bus.pc_write, e_pc);
         chk("if_id_write", bus.if_id_write, e_ifw);
         chk("if_id_flush", bus.if_id_flush, e_iff);
         chk("id_ex_flush", bus.id_ex_flush, e_idf);
         chk("id_ex_hold", bus.id_ex_hold, e_idh);
         chk("ex_mem_hold", bus.ex_mem_hold, e_emh);
         if (reset) begin
            m_wait = 0; m_pend = 0; m_cnt = 0; m_to = 0; m_stalls = 0; m_flushes = 0;
         end else begin
            if (m_wait && busy) begin
               m_cnt = (m_cnt + 1 > MT) ? MT : m_cnt + 1;
               if (m_cnt >= MT) m_to = 1;
            end else begin
               m_cnt = 0;
            end
            m_wait = busy;
            m_pend = lu;
            if (lu && m_stalls < CNT_MAX) m_stalls++;
            if (br && m_flushes < CNT_MAX) m_flushes++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.id_rs = 0; bus.id_rt = 0; bus.id_uses_rt = 0; bus.ex_mem_read = 0;
      bus.ex_rt = 0; bus.ex_pc_src = 0; bus.mem_req = 0; bus.mem_ready = 0;
   endtask

   initial begin
      idle();
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk_en = 1'b1;
      tick();
      chk("rst_pc_write", bus.pc_write, 0);
      chk("rst_if_id_flush", bus.if_id_flush, 1);
      chk("rst_id_ex_flush", bus.id_ex_flush, 1);
      chk("rst_state", bus.state_o, 0);
      chk("rst_counters", {bus.stall_cnt, bus.flush_cnt}, 0);
      reset = 1'b0;

      bus.ex_mem_read = 1; bus.ex_rt = 8; bus.id_rs = 8;
      #1;
      chk("lu_pc_write", bus.pc_write, 0);
      chk("lu_if_id_write", bus.if_id_write, 0);
      chk("lu_id_ex_flush", bus.id_ex_flush, 1);
      tick();
      chk("lu_state_stall", bus.state_o, 1);
      idle();
      tick();
      chk("lu_state_run", bus.state_o, 0);
      chk("lu_stall_cnt", bus.stall_cnt, PERF ? 1 : 0);

      bus.ex_mem_read = 1;
      #1;
      chk("r0_pc_write", bus.pc_write, 1);
      chk("r0_id_ex_flush", bus.id_ex_flush, 0);
      idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;

      bus.ex_mem_read = 1; bus.ex_rt = 8; bus.id_rs = 8; bus.ex_pc_src = 1;
      #1;
      chk("br_if_id_flush", bus.if_id_flush, 1);
      chk("br_id_ex_flush", bus.id_ex_flush, 1);
      chk("br_pc_write", bus.pc_write, 1);
      tick();
      idle();
      chk("br_state", bus.state_o, 0);
      chk("br_flush_cnt", bus.flush_cnt, PERF ? 1 : 0);
      chk("br_stall_cnt", bus.stall_cnt, 0);

      bus.mem_req = 1; bus.mem_ready = 0;
      #1;
      chk("mw_pc_write", bus.pc_write, 0);
      chk("mw_holds", {bus.id_ex_hold, bus.ex_mem_hold}, 2'b11);
      chk("mw_flushes", {bus.if_id_flush, bus.id_ex_flush}, 2'b00);
      tick();
      chk("mw_state", bus.state_o, 2);
      tick();
      tick();
      chk("mw_state3", bus.state_o, 2);
      chk("mw_pc_write3", bus.pc_write, 0);
      bus.mem_ready = 1;
      #1;
      chk("rel_enables", {bus.pc_write, bus.if_id_write, bus.if_id_flush,
                          bus.id_ex_flush, bus.id_ex_hold, bus.ex_mem_hold}, 6'b110000);
      tick();
      chk("rel_state", bus.state_o, 0);
      idle();

      bus.mem_req = 1; bus.mem_ready = 0;
      for (int k = 1; k <= MT + 1; k++) begin
         tick();
         if (k == MT) chk("to_before", bus.mem_timeout, 0);
         if (k == MT + 1) chk("to_set", bus.mem_timeout, 1);
      end
      tick();
      bus.mem_ready = 1;
      tick();
      idle();
      tick();
      chk("to_sticky", bus.mem_timeout, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("to_cleared", bus.mem_timeout, 0);

      for (int i = 0; i < 3000; i++) begin
         reset          = ($urandom_range(0, 63) == 0);
         bus.id_rs      = REG_AW'($urandom_range(0, 3));
         bus.id_rt      = REG_AW'($urandom_range(0, 3));
         bus.ex_rt      = REG_AW'($urandom_range(0, 3));
         bus.id_uses_rt = 1'($urandom_range(0, 1));
         bus.ex_mem_read = 1'($urandom_range(0, 1));
         bus.ex_pc_src  = ($urandom_range(0, 4) == 0);
         bus.mem_req    = 1'($urandom_range(0, 1));
         bus.mem_ready  = ($urandom_range(0, 3) != 0);
         tick();
      end
      reset = 1'b0;
      idle();
      tick();
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
